// File: rtl/scfifo_wr_arbiter_if.sv
// Producer handshake and FIFO write/monitor signals shared by the arbiter
// and its environment. The slave modport is the arbiter's view.
interface scfifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int lpm_widthu = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           fifo_wrreq;
    logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_data;
    logic                           fifo_rdreq;
    logic                           fifo_empty;
    logic [lpm_widthu:0]            usedw;
    logic                           full;
    logic                           underflow_err;

    modport master (
        output req_valid, req_data, fifo_rdreq, fifo_empty,
        input  req_ready, fifo_wrreq, fifo_data, usedw, full, underflow_err
    );

    modport slave (
        input  req_valid, req_data, fifo_rdreq, fifo_empty,
        output req_ready, fifo_wrreq, fifo_data, usedw, full, underflow_err
    );
endinterface

// File: rtl/scfifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single-clock showahead FIFO.
// Grants one producer per cycle while credit remains, registers the
// {id, payload} word onto the FIFO write port and tracks occupancy so the
// FIFO is never written while full.
module scfifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int lpm_numwords = 16,
    parameter int lpm_widthu   = 4
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    scfifo_wr_arbiter_if.slave    bus
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int UW       = lpm_widthu + 1;
    localparam int unsigned L_NREQ = NUM_REQ;
    localparam logic [UW-1:0] L_DEPTH = UW'(lpm_numwords);
    localparam logic [ID_WIDTH-1:0] L_LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]            r_last_grant;
    logic [UW-1:0]                  r_usedw;
    logic                           r_wrreq;
    logic [DATA_WIDTH+ID_WIDTH-1:0] r_data;
    logic                           r_underflow;

    logic                           w_credit;
    logic                           w_found;
    logic                           w_xfer;
    logic                           w_rd;
    logic [NUM_REQ-1:0]             w_grant;
    logic [ID_WIDTH-1:0]            w_grant_id;
    logic [DATA_WIDTH-1:0]          w_grant_data;
    int unsigned                    w_best_dist;
    int unsigned                    w_dist;

    assign w_credit = (r_usedw < L_DEPTH);
    assign w_rd     = bus.fifo_rdreq & ~bus.fifo_empty;
    assign w_xfer   = w_found & w_credit;

    // Pick the valid requester closest after last_grant in rotating order;
    // distance (i - last - 1) mod N ranks requesters without variable indexing.
    always_comb begin
        w_found      = 1'b0;
        w_grant_id   = '0;
        w_grant_data = '0;
        w_best_dist  = L_NREQ;
        w_dist       = 0;
        w_grant      = '0;
        for (int unsigned i = 0; i < L_NREQ; i++) begin
            w_dist = (i + L_NREQ - 1 - int'(r_last_grant)) % L_NREQ;
            if (bus.req_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist  = w_dist;
                w_found      = 1'b1;
                w_grant_id   = ID_WIDTH'(i);
                w_grant_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int unsigned i = 0; i < L_NREQ; i++) begin
            w_grant[i] = w_xfer && (w_grant_id == ID_WIDTH'(i));
        end
    end

    // Register the winning word and remember the winner for rotation.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wrreq      <= 1'b0;
            r_data       <= '0;
            r_last_grant <= L_LAST_INIT;
        end else begin
            r_wrreq <= w_xfer;
            if (w_xfer) begin
                r_data       <= {w_grant_id, w_grant_data};
                r_last_grant <= w_grant_id;
            end
        end
    end

    // Occupancy: +1 per accepted word, -1 per real read, saturating at 0.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_usedw <= '0;
        end else begin
            case ({w_xfer, w_rd})
                2'b10:   r_usedw <= r_usedw + UW'(1);
                2'b01:   if (r_usedw != '0) r_usedw <= r_usedw - UW'(1);
                default: r_usedw <= r_usedw;
            endcase
        end
    end

    // Sticky flag for a read the occupancy count cannot account for.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_underflow <= 1'b0;
        end else if (w_rd && !w_xfer && (r_usedw == '0)) begin
            r_underflow <= 1'b1;
        end
    end

    assign bus.req_ready     = w_grant;
    assign bus.fifo_wrreq    = r_wrreq;
    assign bus.fifo_data     = r_data;
    assign bus.usedw         = r_usedw;
    assign bus.full          = (r_usedw == L_DEPTH);
    assign bus.underflow_err = r_underflow;
endmodule

// File: tb/tb_scfifo_wr_arbiter.sv
// Bench for scfifo_wr_arbiter: table of per-cycle vectors plus hand-written
// fill / read-at-full / underflow / reset sequences. Written words are
// predicted from the expected grant and checked through a queue.
module tb_scfifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int WU    = 4;

    typedef struct {
        logic [3:0] valid;
        logic       rd;
        logic       empty;
        logic [3:0] exp_ready;
        logic [4:0] exp_usedw;
    } vec_t;

    logic clock  = 1'b0;
    logic aclr_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [9:0] sb_q[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    scfifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .lpm_widthu(WU)) bus ();

    scfifo_wr_arbiter #(
        .NUM_REQ(NREQ), .DATA_WIDTH(DW), .lpm_numwords(DEPTH), .lpm_widthu(WU)
    ) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_id(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // One clock cycle: drive, check grant, predict word, check registered outputs.
    task automatic cycle(input string name, input logic [3:0] valid, input logic rd,
                         input logic empty, input logic [3:0] exp_ready,
                         input logic [4:0] exp_usedw, input logic exp_err);
        logic       exp_wr;
        logic [9:0] w;
        int         id;
        bus.req_valid  = valid;
        bus.fifo_rdreq = rd;
        bus.fifo_empty = empty;
        #1;
        chk({name, ".ready"}, 32'(bus.req_ready), 32'(exp_ready));
        exp_wr = (exp_ready != 4'd0);
        if (exp_wr) begin
            id = oh_id(exp_ready);
            sb_q.push_back({2'(id), 8'hA0 + 8'(id)});
        end
        @(posedge clock);
        #1;
        chk({name, ".wrreq"}, 32'(bus.fifo_wrreq), 32'(exp_wr));
        if (bus.fifo_wrreq === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.sb: unexpected write data %0h, nothing expected", name, bus.fifo_data);
            end else begin
                w = sb_q.pop_front();
                chk({name, ".data"}, 32'(bus.fifo_data), 32'(w));
            end
        end
        chk({name, ".usedw"}, 32'(bus.usedw), 32'(exp_usedw));
        chk({name, ".full"}, 32'(bus.full), 32'(exp_usedw == 5'(DEPTH)));
        chk({name, ".err"}, 32'(bus.underflow_err), 32'(exp_err));
    endtask

    // Assert reset off the clock edge, check reset values immediately, release.
    task automatic do_reset(input string name);
        aclr_n = 1'b0;
        #1;
        chk({name, ".wrreq"}, 32'(bus.fifo_wrreq), 32'd0);
        chk({name, ".data"}, 32'(bus.fifo_data), 32'd0);
        chk({name, ".usedw"}, 32'(bus.usedw), 32'd0);
        chk({name, ".full"}, 32'(bus.full), 32'd0);
        chk({name, ".err"}, 32'(bus.underflow_err), 32'd0);
        bus.req_valid  = '0;
        bus.fifo_rdreq = 1'b0;
        bus.fifo_empty = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        aclr_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic add(input logic [3:0] v, input logic rd, input logic e,
                       input logic [3:0] r, input logic [4:0] u);
        vec_t t;
        t.valid = v; t.rd = rd; t.empty = e; t.exp_ready = r; t.exp_usedw = u;
        tbl.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_valid  = '0;
        bus.fifo_rdreq = 1'b0;
        bus.fifo_empty = 1'b1;
        #2;
        do_reset("reset");

        // Round-robin over all four, then sparse 1/3, drain, simultaneous r/w.
        for (int i = 0; i < 8; i++) add(4'hF, 1'b0, 1'b1, 4'(1 << (i % 4)), 5'(i + 1));
        add(4'b1010, 1'b0, 1'b1, 4'b0010, 5'd9);
        add(4'b1010, 1'b0, 1'b1, 4'b1000, 5'd10);
        add(4'b1010, 1'b0, 1'b1, 4'b0010, 5'd11);
        add(4'b1010, 1'b0, 1'b1, 4'b1000, 5'd12);
        for (int i = 0; i < 7; i++) add(4'h0, 1'b1, 1'b0, 4'h0, 5'(11 - i));
        add(4'b0001, 1'b1, 1'b0, 4'b0001, 5'd5);
        add(4'h0, 1'b1, 1'b1, 4'h0, 5'd5);
        add(4'hF, 1'b0, 1'b1, 4'b0010, 5'd6);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].valid, tbl[i].rd, tbl[i].empty,
                  tbl[i].exp_ready, tbl[i].exp_usedw, 1'b0);
        end

        // Fill from requester 2 with no reads, then hold at full.
        do_reset("reset2");
        for (int i = 0; i < DEPTH; i++) cycle("fill", 4'b0100, 1'b0, 1'b1, 4'b0100, 5'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) cycle("full", 4'b0100, 1'b0, 1'b1, 4'h0, 5'd16, 1'b0);

        // Read at full: credit returns only on the following cycle.
        cycle("rd_full", 4'b0100, 1'b1, 1'b0, 4'h0, 5'd15, 1'b0);
        cycle("regrant", 4'b0100, 1'b0, 1'b1, 4'b0100, 5'd16, 1'b0);
        cycle("refull", 4'b0100, 1'b0, 1'b1, 4'h0, 5'd16, 1'b0);

        // Spurious reads: sticky error, usedw saturated at zero.
        do_reset("reset3");
        cycle("spur", 4'h0, 1'b1, 1'b0, 4'h0, 5'd0, 1'b1);
        cycle("sticky", 4'h0, 1'b0, 1'b1, 4'h0, 5'd0, 1'b1);
        cycle("spur2", 4'h0, 1'b1, 1'b0, 4'h0, 5'd0, 1'b1);
        cycle("xfer_err", 4'b0001, 1'b0, 1'b1, 4'b0001, 5'd1, 1'b1);
        cycle("stream1", 4'hF, 1'b0, 1'b1, 4'b0010, 5'd2, 1'b1);
        cycle("stream2", 4'hF, 1'b0, 1'b1, 4'b0100, 5'd3, 1'b1);

        // Mid-stream reset with a word in the output register.
        do_reset("midrst");
        cycle("after_rst", 4'hF, 1'b0, 1'b1, 4'b0001, 5'd1, 1'b0);
        cycle("after_rst2", 4'hF, 1'b0, 1'b1, 4'b0010, 5'd2, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scfifo_wr_arbiter.md
# scfifo_wr_arbiter

Round-robin write-side arbiter that shares one single-clock showahead FIFO (lpm_width = DATA_WIDTH + ID_WIDTH) among NUM_REQ producers. Each producer has a valid/ready port. The arbiter grants one producer per cycle and registers the winning word, tagged with the producer ID, onto the FIFO write port. It tracks FIFO occupancy internally so the FIFO's overflow checking never fires. The block sits directly in front of the FIFO instance; the consumer drives the FIFO read side, and the arbiter only monitors it.

## Interface
Parameters:
- NUM_REQ, 4: number of producers (2..16).
- DATA_WIDTH, 8: payload width per producer.
- lpm_numwords, 16: FIFO depth; must match the FIFO instance.
- lpm_widthu, 4: FIFO address width; lpm_numwords <= 2**lpm_widthu.
- ID_WIDTH, $clog2(NUM_REQ): derived; width of the requester tag.

Ports:
- clock  in  1  sole clock, rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  producer i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  producer i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- fifo_wrreq  out  1  FIFO write enable; registered.
- fifo_data  out  DATA_WIDTH+ID_WIDTH  {id, payload}; registered.
- fifo_rdreq  in  1  consumer read request, monitored.
- fifo_empty  in  1  FIFO empty flag, monitored.
- usedw  out  lpm_widthu+1  internal occupancy count; registered.
- full  out  1  usedw == lpm_numwords.
- underflow_err  out  1  sticky error; registered.

## Operation
- **Credit.** A grant is allowed only when usedw < lpm_numwords.
- **Grant selection.** req_ready is the first asserted req_valid bit, searching from (last_grant+1) mod NUM_REQ upward and wrapping. It is all-zero when no credit is available or no request is present. At most one bit is set.
- **Transfer.** A transfer occurs on a rising edge where req_valid[i] & req_ready[i]. On that edge:
  - fifo_data <= {i, req_data[i]}.
  - fifo_wrreq <= 1.
  - last_grant <= i.
- **No transfer.** fifo_wrreq <= 0; fifo_data holds its value; last_grant holds.
- **Occupancy.** usedw increments on a transfer and decrements when fifo_rdreq & ~fifo_empty.
  - Both on the same edge: usedw is unchanged.
  - A read does not free credit in the same cycle; credit reflects registered usedw only.
- **Error.** Sets when fifo_rdreq & ~fifo_empty with usedw == 0 and no transfer on that edge. Once set, underflow_err stays at 1 until reset, and usedw saturates at 0 in that case.
- **Producer rules.** Producers may drop req_valid without a grant; the arbiter holds no per-producer state beyond last_grant.

## Timing
- **Reset values:**
  - fifo_wrreq = 0.
  - fifo_data = 0.
  - usedw = 0.
  - full = 0.
  - underflow_err = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- **Reset release.** Reset is asynchronous assert. The first grant can occur on the first edge after release.
- **Latency.** Handshake edge to fifo_wrreq high is 1 cycle. A showahead FIFO presents the word at its q output no earlier than 1 cycle after that.
- **Throughput.** One word per cycle while credit remains.
- **Occupancy accounting.** usedw counts accepted words, including the one still in the output register. usedw therefore leads the FIFO's own count by at most 1, so the FIFO never receives wrreq when full.
- **Full boundary.** At usedw == lpm_numwords-1 one more grant is allowed; the next cycle full = 1 and req_ready = 0.
- **Simultaneous read at full.** With full = 1 and a read on edge N, usedw drops on edge N. The grant reappears in cycle N+1.
- **Reset mid-operation.** A word held in the output register is discarded, and fifo_wrreq drops immediately. Resetting the FIFO itself is the system's responsibility.

## Test plan
- **Round-robin.** After reset, all four req_valid held high with data 0xA0..0xA3 for 8 cycles. fifo_data ID sequence must be 0,1,2,3,0,1,2,3 with payloads matching; fifo_wrreq high every cycle from cycle 2.
- **Sparse requests.** Only requesters 1 and 3 assert. Grants must alternate 1,3,1,3; req_ready[0] and req_ready[2] stay 0.
- **Fill without reads.** No reads, requester 2 streams. Exactly 16 transfers occur, then full = 1, req_ready = 0, usedw = 16. The FIFO never sees wrreq while its full flag is set.
- **Read at full.** At full, pulse fifo_rdreq with fifo_empty = 0 for one cycle. usedw goes 16→15, then one grant is issued the following cycle and usedw returns to 16.
- **Simultaneous transfer and read.** usedw = 5, a transfer and a valid read on the same edge. usedw stays 5.
- **Spurious read and mid-stream reset.** A spurious read with usedw = 0 and fifo_empty = 0 sets underflow_err = 1, which persists; usedw stays 0. Then assert aclr_n low mid-stream: all outputs go to reset values asynchronously, and requester 0 is granted first after release.
